// File: rtl/frame_sequencer_if.sv
// Bundle of the pixel stream, datapath control and object-report signals
// shared between the frame sequencer (master) and the pixel pipeline side (slave).
interface frame_sequencer_if;
   logic        in_valid;
   logic        in_ready;
   logic        out_valid;
   logic        out_ready;
   logic        pipe_en;
   logic [15:0] pipe_x;
   logic [15:0] pipe_y;
   logic [7:0]  pipe_obj_id;
   logic [15:0] obj_x_in;
   logic [15:0] obj_y_in;
   logic        rpt_valid;
   logic        rpt_ready;
   logic [7:0]  rpt_id;
   logic [15:0] rpt_x;
   logic [15:0] rpt_y;

   modport master (
      input  in_valid, out_ready, obj_x_in, obj_y_in, rpt_ready,
      output in_ready, out_valid, pipe_en, pipe_x, pipe_y, pipe_obj_id,
             rpt_valid, rpt_id, rpt_x, rpt_y
   );

   modport slave (
      output in_valid, out_ready, obj_x_in, obj_y_in, rpt_ready,
      input  in_ready, out_valid, pipe_en, pipe_x, pipe_y, pipe_obj_id,
             rpt_valid, rpt_id, rpt_x, rpt_y
   );
endinterface

// File: rtl/frame_sequencer.sv
// Frame sequencer: streams one frame of pixels through the pixel pipeline,
// flushes the pipeline's row buffers, then walks the object table and emits
// one coordinate report per non-background object.
module frame_sequencer #(
   parameter int FRAME_WIDTH  = 640,
   parameter int FRAME_HEIGHT = 480,
   parameter int LATENCY      = 643,
   parameter int MAX_OBJ      = 256,
   parameter int OBJ_LAT      = 1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   frame_sequencer_if.master bus,
   output logic              busy,
   output logic              done
);
   localparam int NPIX  = FRAME_WIDTH * FRAME_HEIGHT;
   localparam int TOTAL = NPIX + LATENCY;
   localparam int CNT_W = $clog2(TOTAL);
   localparam int LAT_W = (OBJ_LAT > 1) ? $clog2(OBJ_LAT) : 1;

   localparam logic [CNT_W-1:0] CNT_LAT      = CNT_W'(LATENCY);
   localparam logic [CNT_W-1:0] CNT_PIX_LAST = CNT_W'(NPIX - 1);
   localparam logic [CNT_W-1:0] CNT_END      = CNT_W'(TOTAL - 1);
   localparam logic [LAT_W-1:0] LAT_LAST     = LAT_W'(OBJ_LAT - 1);
   localparam logic [7:0]       ID_LAST      = 8'(MAX_OBJ - 1);
   localparam logic [15:0]      X_LAST       = 16'(FRAME_WIDTH - 1);
   localparam logic [15:0]      Y_LAST       = 16'(FRAME_HEIGHT - 1);

   // RD_FINISH is the final readout cycle carrying the done pulse, so a start
   // arriving alongside done is still seen outside IDLE and ignored.
   typedef enum logic [2:0] {
      S_IDLE,
      S_STREAM,
      S_FLUSH,
      S_RD_WAIT,
      S_RD_PRESENT,
      S_RD_FINISH
   } state_t;

   state_t           state, next_state;
   logic [CNT_W-1:0] issue_cnt;
   logic [LAT_W-1:0] lat_cnt;
   logic             pipe_en;
   logic             in_ready;
   logic [15:0]      pipe_x, pipe_y;
   logic [7:0]       pipe_obj_id;
   logic             rpt_valid;
   logic [7:0]       rpt_id;
   logic [15:0]      rpt_x, rpt_y;

   assign bus.pipe_en     = pipe_en;
   assign bus.in_ready    = in_ready;
   assign bus.out_valid   = pipe_en & (issue_cnt >= CNT_LAT);
   assign bus.pipe_x      = pipe_x;
   assign bus.pipe_y      = pipe_y;
   assign bus.pipe_obj_id = pipe_obj_id;
   assign bus.rpt_valid   = rpt_valid;
   assign bus.rpt_id      = rpt_id;
   assign bus.rpt_x       = rpt_x;
   assign bus.rpt_y       = rpt_y;
   assign busy            = (state != S_IDLE);

   // State register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= S_IDLE;
      else       state <= next_state;
   end

   // Next-state decode plus the combinational enable/consume strobes.
   always_comb begin
      next_state = state;
      pipe_en    = 1'b0;
      in_ready   = 1'b0;
      case (state)
         S_IDLE: begin
            if (start) next_state = S_STREAM;
         end
         S_STREAM: begin
            // Only enable when downstream can take the pipeline's output.
            pipe_en  = bus.in_valid & bus.out_ready;
            in_ready = pipe_en;
            if (pipe_en && issue_cnt == CNT_PIX_LAST) next_state = S_FLUSH;
         end
         S_FLUSH: begin
            pipe_en = bus.out_ready;
            if (pipe_en && issue_cnt == CNT_END) next_state = S_RD_WAIT;
         end
         S_RD_WAIT: begin
            if (lat_cnt == LAT_LAST) next_state = S_RD_PRESENT;
         end
         S_RD_PRESENT: begin
            if (bus.rpt_ready) next_state = (rpt_id == ID_LAST) ? S_RD_FINISH : S_RD_WAIT;
         end
         S_RD_FINISH: begin
            next_state = S_IDLE;
         end
         default: next_state = S_IDLE;
      endcase
   end

   // Issue/raster counters, object walk and report registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         issue_cnt   <= '0;
         lat_cnt     <= '0;
         pipe_x      <= '0;
         pipe_y      <= '0;
         pipe_obj_id <= '0;
         rpt_valid   <= 1'b0;
         rpt_id      <= '0;
         rpt_x       <= '0;
         rpt_y       <= '0;
         done        <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            S_IDLE: begin
               if (start) begin
                  issue_cnt <= '0;
                  pipe_x    <= '0;
                  pipe_y    <= '0;
               end
            end
            S_STREAM, S_FLUSH: begin
               if (pipe_en) begin
                  issue_cnt <= issue_cnt + CNT_W'(1);
                  if (pipe_x == X_LAST) begin
                     pipe_x <= '0;
                     pipe_y <= (pipe_y == Y_LAST) ? 16'd0 : pipe_y + 16'd1;
                  end else begin
                     pipe_x <= pipe_x + 16'd1;
                  end
                  if (state == S_FLUSH && issue_cnt == CNT_END) begin
                     pipe_obj_id <= 8'd1;
                     lat_cnt     <= '0;
                  end
               end
            end
            S_RD_WAIT: begin
               if (lat_cnt == LAT_LAST) begin
                  rpt_valid <= 1'b1;
                  rpt_id    <= pipe_obj_id;
                  rpt_x     <= bus.obj_x_in;
                  rpt_y     <= bus.obj_y_in;
               end else begin
                  lat_cnt <= lat_cnt + LAT_W'(1);
               end
            end
            S_RD_PRESENT: begin
               if (bus.rpt_ready) begin
                  rpt_valid <= 1'b0;
                  if (rpt_id == ID_LAST) begin
                     done <= 1'b1;
                  end else begin
                     pipe_obj_id <= pipe_obj_id + 8'd1;
                     lat_cnt     <= '0;
                  end
               end
            end
            default: ;
         endcase
      end
   end
endmodule

// File: doc/frame_sequencer.md
Name: frame_sequencer

Overview:
- Controller that sequences the pixel pipeline (gray → Sobel → threshold → connected-components) for one frame per start pulse.
- Accepts a valid/ready pixel stream and drives the pipeline enable plus raster x/y.
- After the last pixel it flushes the row buffers with extra enable cycles.
- It then walks obj_id through the object table and emits one coordinate report per object.

Parameters:
- FRAME_WIDTH, 640, pixels per row (≥2)
- FRAME_HEIGHT, 480, rows per frame (≥2)
- LATENCY, 643, pipeline enable cycles from pixel issue to its result at the pipeline output
- MAX_OBJ, 256, number of object-table entries; ids 1..MAX_OBJ-1 are reported (0 = background)
- OBJ_LAT, 1, cycles from pipe_obj_id change to valid obj_x_in/obj_y_in (≥1)

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- start  in  1  begin a frame; sampled only in IDLE
- in_valid  in  1  upstream pixel available
- in_ready  out  1  pixel consumed this cycle
- out_valid  out  1  pipeline output pixel corresponds to a real frame pixel
- out_ready  in  1  downstream can accept an output pixel
- pipe_en  out  1  datapath enable
- pipe_x  out  16  raster column of the pixel issued this cycle
- pipe_y  out  16  raster row of the pixel issued this cycle
- pipe_obj_id  out  8  object index driven to the datapath
- obj_x_in  in  16  object x from the datapath
- obj_y_in  in  16  object y from the datapath
- rpt_valid  out  1  object report valid
- rpt_ready  in  1  report consumer ready
- rpt_id  out  8  reported object id
- rpt_x  out  16  reported object x
- rpt_y  out  16  reported object y
- busy  out  1  state != IDLE
- done  out  1  one-cycle pulse when readout completes

Behaviour:
- Reset (asynchronous, any state):
  - State goes to IDLE.
  - All counters and registered outputs clear to 0: pipe_x, pipe_y, pipe_obj_id, rpt_*, done.
  - The aborted frame is discarded and no done pulse is produced.
- States: IDLE, STREAM, FLUSH, READOUT (sub-phases WAIT, PRESENT).
- IDLE:
  - pipe_en = in_ready = out_valid = rpt_valid = 0.
  - start=1 → STREAM next cycle; issue_cnt, pipe_x, pipe_y cleared.
- STREAM:
  - pipe_en = in_ready = in_valid & out_ready (combinational).
  - No enable unless downstream is ready, so the pipeline never drops an output.
- FLUSH:
  - pipe_en = out_ready, in_ready = 0.
  - Exactly LATENCY enable cycles are issued.
- Issue counter:
  - issue_cnt increments on every pipe_en.
  - Range 0..FRAME_WIDTH*FRAME_HEIGHT+LATENCY-1, width sized to hold that range.
- out_valid = pipe_en & (issue_cnt ≥ LATENCY).
  - Exactly FRAME_WIDTH*FRAME_HEIGHT out_valid beats per frame, the last one on the final FLUSH enable.
- Transitions:
  - STREAM → FLUSH on the enable where issue_cnt = W*H-1.
  - FLUSH → READOUT on the enable where issue_cnt = W*H+LATENCY-1.
- Raster counters: pipe_x/pipe_y advance on every pipe_en, including FLUSH.
  - x wraps FRAME_WIDTH-1 → 0 and increments y.
  - y wraps FRAME_HEIGHT-1 → 0.
  - x=W-1, y=H-1 → (0,0).
- READOUT:
  - pipe_en = 0; the datapath table is frozen.
  - On entry, pipe_obj_id = 1.
  - WAIT: count OBJ_LAT cycles, then capture obj_x_in/obj_y_in into rpt_x/rpt_y and set rpt_id = pipe_obj_id, rpt_valid = 1 (PRESENT).
  - PRESENT: rpt_* held stable while rpt_valid & !rpt_ready.
  - On handshake with id < MAX_OBJ-1: rpt_valid drops, pipe_obj_id increments, re-enter WAIT.
  - On handshake with id = MAX_OBJ-1: rpt_valid drops, done=1 for one cycle, state → IDLE.
- Simultaneous events / edge cases:
  - start outside IDLE is ignored.
  - start on the same cycle as done is ignored (state is still READOUT).
  - in_valid with out_ready=0 gives no enable and no consumption.
  - rpt_ready without rpt_valid has no effect.
- busy = (state != IDLE), combinational.

Test Plan:
- Reset: W=4, H=3, LATENCY=5, MAX_OBJ=4.
  - Assert reset mid-STREAM after 6 pixels → same cycle busy=0, pipe_x=pipe_y=0, in_ready=0.
  - A new start re-streams from (0,0).
- Full-throughput frame (same params): in_valid=out_ready=1 continuously.
  - in_ready high exactly 12 cycles.
  - FLUSH gives 5 enables.
  - out_valid first on enable #6 (issue_cnt=5); 12 out_valid beats total.
  - pipe_x/pipe_y sequence (0,0),(1,0)…(3,2), then flush (0,0)…(0,1).
- Back-pressure: toggle out_ready 1/0 every cycle during STREAM and FLUSH.
  - pipe_en never high while out_ready=0.
  - Frame still yields 12 out_valid beats; total enables = 17.
- Readout: obj_x_in = 10·id, obj_y_in = 20·id (OBJ_LAT=1), rpt_ready stalled 3 cycles on id 2.
  - Reports (1,10,20), (2,20,40), (3,30,60) in order; id 2 fields held stable during the stall.
  - done pulses once after id 3; then busy=0.
- Start ignored: pulse start during FLUSH and on the done cycle.
  - No restart; the next frame begins only from a start pulse while in IDLE.
- Starved input: in_valid low 4 cycles mid-row (x=2,y=1).
  - pipe_x/pipe_y hold (2,1) and out_valid stays 0 for those 4 cycles.
